// File: rtl/seg7_multi_ctrl.sv
// Multiplexed 7-segment display controller: digit scanning, PWM brightness,
// windowed data latch with optional idle clear, and leading-zero blanking.
module seg7_multi_ctrl #(
  parameter int NUM_DIGITS  = 4,
  parameter int TICK_DIV    = 250000,
  parameter int HOLD_TICKS  = 200,
  parameter bit CLR_ON_IDLE = 1'b1
) (
  input  logic                    clk_sys,
  input  logic                    rst_n,
  input  logic                    din_vld,
  input  logic [4*NUM_DIGITS-1:0] din,
  input  logic [NUM_DIGITS-1:0]   dot_in,
  input  logic                    mode_lzb,
  input  logic [2:0]              bright,
  output logic [NUM_DIGITS-1:0]   seg_sel_n,
  output logic [7:0]              hex_n,
  output logic                    upd_pulse
);

  localparam int SLOT_W  = $clog2(TICK_DIV);
  localparam int SUB_LEN = TICK_DIV / 8;
  localparam int SUB_W   = $clog2(SUB_LEN);
  localparam int HOLD_W  = $clog2(HOLD_TICKS);
  localparam int IDX_W   = $clog2(NUM_DIGITS);

  logic [SLOT_W-1:0]       slot_cnt;
  logic [SUB_W-1:0]        sub_cnt;
  logic [2:0]              sub_phase;
  logic [IDX_W-1:0]        digit_idx;
  logic [HOLD_W-1:0]       hold_cnt;
  logic [2:0]              bright_q;
  logic                    armed;
  logic [4*NUM_DIGITS-1:0] data_q;
  logic [NUM_DIGITS-1:0]   dot_q;
  logic                    tick;
  logic                    hold_tick;

  assign tick      = (slot_cnt == SLOT_W'(TICK_DIV - 1));
  assign hold_tick = tick && (hold_cnt == HOLD_W'(HOLD_TICKS - 1));

  // sub_cnt/sub_phase run in lockstep with slot_cnt, so sub_phase equals slot_cnt / SUB_LEN
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      slot_cnt  <= '0;
      sub_cnt   <= '0;
      sub_phase <= '0;
      digit_idx <= '0;
      hold_cnt  <= '0;
      bright_q  <= '0;
    end else if (tick) begin
      slot_cnt  <= '0;
      sub_cnt   <= '0;
      sub_phase <= '0;
      bright_q  <= bright;
      digit_idx <= (digit_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : digit_idx + 1'b1;
      hold_cnt  <= hold_tick ? '0 : hold_cnt + 1'b1;
    end else begin
      slot_cnt <= slot_cnt + 1'b1;
      if (sub_cnt == SUB_W'(SUB_LEN - 1)) begin
        sub_cnt   <= '0;
        sub_phase <= sub_phase + 1'b1;
      end else begin
        sub_cnt <= sub_cnt + 1'b1;
      end
    end
  end

  // din_vld is a one-cycle strobe with no ready: it is taken only while armed
  // (once per hold window) and silently dropped otherwise; a take beats hold_tick.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      armed     <= 1'b0;
      data_q    <= '0;
      dot_q     <= '0;
      upd_pulse <= 1'b0;
    end else begin
      upd_pulse <= 1'b0;
      if (din_vld && armed) begin
        data_q    <= din;
        dot_q     <= dot_in;
        upd_pulse <= 1'b1;
        armed     <= 1'b0;
      end else if (hold_tick) begin
        armed <= 1'b1;
        if (armed && CLR_ON_IDLE) begin
          data_q <= '0;
          dot_q  <= '0;
        end
      end
    end
  end

  logic [NUM_DIGITS-1:0] zero_from;
  logic                  run_zero;
  logic [3:0]            cur_nib;
  logic                  cur_dot;
  logic                  cur_zero;
  logic                  cur_blank;
  logic                  cur_on;

  // zero_from[k]: nibbles and dots k..top are all zero
  always_comb begin
    run_zero  = 1'b1;
    zero_from = '0;
    cur_nib   = '0;
    cur_dot   = 1'b0;
    cur_zero  = 1'b0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      run_zero     = run_zero && (data_q[4*k +: 4] == 4'h0) && !dot_q[k];
      zero_from[k] = run_zero;
    end
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (digit_idx == IDX_W'(k)) begin
        cur_nib  = data_q[4*k +: 4];
        cur_dot  = dot_q[k];
        cur_zero = zero_from[k];
      end
    end
    cur_blank = mode_lzb && (digit_idx != '0) && cur_zero;
    cur_on    = (sub_phase <= bright_q);
  end

  logic [IDX_W-1:0]      s1_idx;
  logic [3:0]            s1_nib;
  logic                  s1_dot;
  logic                  s1_blank;
  logic                  s1_on;
  logic [NUM_DIGITS-1:0] s1_oh;

  always_comb begin
    s1_oh = '0;
    for (int k = 0; k < NUM_DIGITS; k++) s1_oh[k] = (s1_idx == IDX_W'(k));
  end

  function automatic logic [6:0] glyph(input logic [3:0] nib);
    case (nib)
      4'h0: glyph = 7'h40;  4'h1: glyph = 7'h79;  4'h2: glyph = 7'h24;  4'h3: glyph = 7'h30;
      4'h4: glyph = 7'h19;  4'h5: glyph = 7'h12;  4'h6: glyph = 7'h02;  4'h7: glyph = 7'h78;
      4'h8: glyph = 7'h00;  4'h9: glyph = 7'h10;  4'hA: glyph = 7'h08;  4'hB: glyph = 7'h03;
      4'hC: glyph = 7'h46;  4'hD: glyph = 7'h21;  4'hE: glyph = 7'h06;  default: glyph = 7'h0E;
    endcase
  endfunction

  // Anode and segments leave the same register stage, so they always switch together
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      s1_idx    <= '0;
      s1_nib    <= '0;
      s1_dot    <= 1'b0;
      s1_blank  <= 1'b0;
      s1_on     <= 1'b0;
      seg_sel_n <= '1;
      hex_n     <= 8'hFF;
    end else begin
      s1_idx   <= digit_idx;
      s1_nib   <= cur_nib;
      s1_dot   <= cur_dot;
      s1_blank <= cur_blank;
      s1_on    <= cur_on;
      if (s1_blank) begin
        seg_sel_n <= '1;
        hex_n     <= 8'hFF;
      end else begin
        seg_sel_n <= s1_on ? ~s1_oh : '1;
        hex_n     <= {~s1_dot, glyph(s1_nib)};
      end
    end
  end

endmodule
